// File: rtl/oh_pwrgood_pkg.sv
// Shared definitions for the power-good sequencer.
//   pwr_state_e : FSM state encoding (OFF=00, WAIT=01, ON=10)
//   SyncMin     : smallest synchronizer depth that is ever built
package oh_pwrgood_pkg;

  typedef enum logic [1:0] {
    StOff  = 2'b00,
    StWait = 2'b01,
    StOn   = 2'b10
  } pwr_state_e;

  localparam int unsigned SyncMin = 2;

endpackage

// File: rtl/asic_and4.sv
// 4-input AND cell.
//   a0..a3 : inputs
//   z      : a0 & a1 & a2 & a3
module asic_and4 (
  input  logic a0,
  input  logic a1,
  input  logic a2,
  input  logic a3,
  output logic z
);

  assign z = a0 & a1 & a2 & a3;

endmodule

// File: rtl/oh_pwrgood_sync.sv
// Multi-stage flop synchronizer with asynchronous active-low reset.
//   clk    : destination clock
//   nreset : asynchronous active-low reset, clears every stage
//   d      : asynchronous input bits
//   q      : synchronized output bits (STAGES cycles of latency)
module oh_pwrgood_sync
  import oh_pwrgood_pkg::*;
#(
  parameter int unsigned W      = 4,
  parameter int unsigned STAGES = 2
) (
  input  logic         clk,
  input  logic         nreset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Never build a chain shorter than the metastability minimum.
  localparam int unsigned Stages = (STAGES < SyncMin) ? SyncMin : STAGES;

  logic [W-1:0] stage_q [Stages];

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      for (int i = 0; i < Stages; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= d;
      for (int i = 1; i < Stages; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q = stage_q[Stages-1];

endmodule

// File: rtl/oh_pwrgood_seq.sv
// Power-good sequencer: synchronizes four asynchronous good flags, ANDs
// them, qualifies the result with a hold-off counter and drives a clean
// registered ready level plus one-cycle rise/fall pulses.
//   clk        : clock, all state on rising edge
//   nreset     : asynchronous active-low reset (release must be clk-synchronous)
//   good_in    : asynchronous good flags
//   en         : synchronous enable, 0 forces not-ready at the next edge
//   ready      : registered qualified all-good level
//   rise_pulse : one-cycle pulse on the edge ready goes 0->1
//   fall_pulse : one-cycle pulse on the edge ready goes 1->0
// Optional (OH_PWRGOOD_FAULT_EN defined):
//   fault_clr  : clears the sticky fault vector at the next edge
//   fault      : sticky record of flags that were low on an ON->OFF drop
module oh_pwrgood_seq
  import oh_pwrgood_pkg::*;
#(
  parameter int unsigned SYNC = 2,
  parameter int unsigned HOLD = 16
) (
  input  logic       clk,
  input  logic       nreset,
`ifdef OH_PWRGOOD_FAULT_EN
  input  logic       fault_clr,
  output logic [3:0] fault,
`endif
  input  logic [3:0] good_in,
  input  logic       en,
  output logic       ready,
  output logic       rise_pulse,
  output logic       fall_pulse
);

  localparam int unsigned CW = $clog2(HOLD + 1);
  localparam logic [CW-1:0] HoldLast = CW'(HOLD - 1);
  localparam int unsigned SyncStages = (SYNC < SyncMin) ? SyncMin : SYNC;

  logic [3:0]    good_s;
  logic          and_ok;
  logic          all_ok;
  pwr_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ready_q, ready_d;
  logic          rise_q, fall_q;

  oh_pwrgood_sync #(
    .W      (4),
    .STAGES (SyncStages)
  ) u_sync (
    .clk    (clk),
    .nreset (nreset),
    .d      (good_in),
    .q      (good_s)
  );

  asic_and4 u_and4 (
    .a0 (good_s[0]),
    .a1 (good_s[1]),
    .a2 (good_s[2]),
    .a3 (good_s[3]),
    .z  (and_ok)
  );

  // en is already synchronous, so it gates after the synchronizer.
  assign all_ok = and_ok & en;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StOff: begin
        cnt_d = '0;
        if (all_ok) begin
          cnt_d   = CW'(1);
          state_d = (HOLD == 1) ? StOn : StWait;
        end
      end
      StWait: begin
        // Any single low cycle restarts qualification from scratch.
        if (!all_ok) begin
          state_d = StOff;
          cnt_d   = '0;
        end else if (cnt_q == HoldLast) begin
          state_d = StOn;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      StOn: begin
        if (!all_ok) begin
          state_d = StOff;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = StOff;
        cnt_d   = '0;
      end
    endcase
  end

  assign ready_d = (state_d == StOn);

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q <= StOff;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      rise_q  <= ready_d & ~ready_q;
      fall_q  <= ~ready_d & ready_q;
    end
  end

  assign ready      = ready_q;
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;

`ifdef OH_PWRGOOD_FAULT_EN
  logic [3:0] fault_q, fault_d;

  // A clear and a new capture in the same cycle keep the new bits.
  always_comb begin
    fault_d = fault_clr ? 4'h0 : fault_q;
    if (state_q == StOn && en && !and_ok) fault_d = fault_d | ~good_s;
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) fault_q <= 4'h0;
    else         fault_q <= fault_d;
  end

  assign fault = fault_q;
`endif

endmodule

// File: tb/tb_oh_pwrgood_seq.sv
// Directed bench for oh_pwrgood_seq with SYNC=2, HOLD=4.
module tb_oh_pwrgood_seq;
  import oh_pwrgood_pkg::*;

  logic       clk = 1'b0;
  logic       nreset;
  logic [3:0] good_in;
  logic       en;
  logic       ready;
  logic       rise_pulse;
  logic       fall_pulse;
`ifdef OH_PWRGOOD_FAULT_EN
  logic       fault_clr;
  logic [3:0] fault;
`endif

  int vectors = 0;
  int miscompares = 0;

  oh_pwrgood_seq #(
    .SYNC (2),
    .HOLD (4)
  ) dut (
    .clk        (clk),
    .nreset     (nreset),
`ifdef OH_PWRGOOD_FAULT_EN
    .fault_clr  (fault_clr),
    .fault      (fault),
`endif
    .good_in    (good_in),
    .en         (en),
    .ready      (ready),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // {ready, rise_pulse, fall_pulse}
  task automatic chk_out(input string tag, input logic r, input logic rp, input logic fp);
    chk(tag, {1'b0, ready, rise_pulse, fall_pulse}, {1'b0, r, rp, fp});
  endtask

  task automatic chk_state(input string tag, input pwr_state_e st);
    chk(tag, {2'b00, dut.state_q}, {2'b00, st});
  endtask

  initial begin
    nreset  = 1'b0;
    good_in = 4'h0;
    en      = 1'b0;
`ifdef OH_PWRGOOD_FAULT_EN
    fault_clr = 1'b0;
`endif
    #1;
    chk_out("reset_out", 1'b0, 1'b0, 1'b0);
    chk_state("reset_state", StOff);
`ifdef OH_PWRGOOD_FAULT_EN
    chk("reset_fault", fault, 4'h0);
`endif
    tick();
    tick();
    nreset = 1'b1;

    // 1: all flags high after edge 0 -> ready at edge 6
    good_in = 4'hF;
    en      = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk_out("s1_qualify", 1'b0, 1'b0, 1'b0);
    end
    tick();
    chk_out("s1_rise", 1'b1, 1'b1, 1'b0);
    tick();
    chk_out("s1_steady", 1'b1, 1'b0, 1'b0);

    // 2: drop flag 2 -> ready low with fall pulse at edge 3
    good_in = 4'hB;
    tick();
    chk_out("s2_e1", 1'b1, 1'b0, 1'b0);
    tick();
    chk_out("s2_e2", 1'b1, 1'b0, 1'b0);
    tick();
    chk_out("s2_fall", 1'b0, 1'b0, 1'b1);
    tick();
    chk_out("s2_after", 1'b0, 1'b0, 1'b0);

    // 3: one-cycle glitch on flag 0 while WAIT with cnt=2
    good_in = 4'hF;
    tick();
    tick();
    good_in = 4'hE;
    tick();
    chk_state("s3_wait1", StWait);
    good_in = 4'hF;
    tick();
    chk_state("s3_wait2", StWait);
    chk(4'(0) == 4'(0) ? "s3_cnt2" : "", {1'b0, dut.cnt_q}, 4'h2);
    tick();
    chk_state("s3_off", StOff);
    tick();
    tick();
    tick();
    chk_out("s3_e8", 1'b0, 1'b0, 1'b0);
    tick();
    chk_out("s3_rise", 1'b1, 1'b1, 1'b0);

    // 4: en low -> not ready next edge; en high -> ready 4 edges later
    en = 1'b0;
    tick();
    chk_out("s4_en_off", 1'b0, 1'b0, 1'b1);
    en = 1'b1;
    tick();
    chk_state("s4_wait", StWait);
    tick();
    tick();
    chk_out("s4_e3", 1'b0, 1'b0, 1'b0);
    tick();
    chk_out("s4_rise", 1'b1, 1'b1, 1'b0);

    // 5a: reset mid-WAIT
    en = 1'b0;
    tick();
    en = 1'b1;
    tick();
    chk_state("s5_wait", StWait);
    #2;
    nreset = 1'b0;
    #1;
    chk_state("s5_wait_rst", StOff);
    chk_out("s5_wait_rst_out", 1'b0, 1'b0, 1'b0);
    tick();
    nreset = 1'b1;
    for (int i = 1; i <= 5; i++) tick();
    chk_out("s5_rec1_e5", 1'b0, 1'b0, 1'b0);
    tick();
    chk_out("s5_rec1_rise", 1'b1, 1'b1, 1'b0);

    // 5b: reset mid-ON -> outputs drop immediately, no fall pulse
    #2;
    nreset = 1'b0;
    #1;
    chk_out("s5_on_rst", 1'b0, 1'b0, 1'b0);
    tick();
    chk_out("s5_on_rst_hold", 1'b0, 1'b0, 1'b0);
    nreset = 1'b1;
    for (int i = 1; i <= 5; i++) tick();
    chk_out("s5_rec2_e5", 1'b0, 1'b0, 1'b0);
    tick();
    chk_out("s5_rec2_rise", 1'b1, 1'b1, 1'b0);

`ifdef OH_PWRGOOD_FAULT_EN
    // 6: sticky fault capture and clear
    good_in = 4'hD;
    tick();
    tick();
    tick();
    chk_out("s6_fall", 1'b0, 1'b0, 1'b1);
    chk("s6_fault_set", fault, 4'h2);
    good_in = 4'hF;
    for (int i = 1; i <= 6; i++) tick();
    chk_out("s6_on_again", 1'b1, 1'b1, 1'b0);
    chk("s6_fault_sticky", fault, 4'h2);
    good_in = 4'h7;
    tick();
    tick();
    fault_clr = 1'b1;
    tick();
    chk("s6_set_wins", fault, 4'h8);
    good_in = 4'hF;
    tick();
    chk("s6_cleared", fault, 4'h0);
    fault_clr = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
